// File: rtl/pe_pkg.sv
// pe_pkg: shared mode enum, widened-accumulator sizing and the saturate/truncate helper.
package pe_pkg;
    typedef enum logic {PE_MODE_WS, PE_MODE_OS} pe_mode_e;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovf;
    } sat_t;

    function automatic int wide_w(input int accum_w, input int lanes);
        return accum_w + $clog2(lanes) + 1;
    endfunction

    // Range-checks v against a signed width-bit range; the caller keeps the low width bits.
    function automatic sat_t sat_trunc(input logic signed [SAT_W-1:0] v, input int width, input bit clamp);
        logic signed [SAT_W-1:0] mx, mn;
        sat_t r;
        mx = $signed((64'd1 << (width - 1)) - 64'd1);
        mn = ~mx;
        r.ovf = (v > mx) || (v < mn);
        r.value = !clamp ? v : (v > mx) ? mx : (v < mn) ? mn : v;
        return r;
    endfunction
endpackage

// File: rtl/pe_dot_lanes.sv
// pe_dot_lanes: combinational signed LANES-term dot product, full-width products.
module pe_dot_lanes #(
    parameter int LANES         = 1,
    parameter int DATA_WIDTH_IN = 8,
    parameter int OUT_W         = 33
) (
    input  logic [LANES*DATA_WIDTH_IN-1:0] a,
    input  logic [LANES*DATA_WIDTH_IN-1:0] b,
    output logic signed [OUT_W-1:0]        dot
);
    always_comb begin : sum_lanes
        logic signed [OUT_W-1:0] x, y;
        dot = '0;
        for (int i = 0; i < LANES; i++) begin
            x = OUT_W'($signed(a[i*DATA_WIDTH_IN +: DATA_WIDTH_IN]));
            y = OUT_W'($signed(b[i*DATA_WIDTH_IN +: DATA_WIDTH_IN]));
            dot = dot + x * y;
        end
    end
endmodule

// File: rtl/pe_dual_mode.sv
// pe_dual_mode: systolic PE with runtime weight-stationary / output-stationary dataflow,
// LANES-wide dot-product MAC, optional saturation and sticky overflow/collision flags.
module pe_dual_mode
    import pe_pkg::*;
#(
    parameter int ROW_ID               = 0,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_IN        = 8,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int LANES                = 1,
    parameter int SATURATE             = 1,
    localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH),
    localparam int VW = LANES * DATA_WIDTH_IN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pe_enabled,
    input  logic                        pe_mode,
    input  logic                        pe_valid_in,
    input  logic                        pe_switch_in,
    input  logic                        pe_drain_in,
    input  logic [VW-1:0]               pe_input_in,
    input  logic                        pe_accept_w_in,
    input  logic [VW-1:0]               pe_weight_in,
    input  logic [IW-1:0]               pe_index_in,
    input  logic [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
    input  logic                        pe_psum_valid_in,
    output logic [VW-1:0]               pe_input_out,
    output logic                        pe_valid_out,
    output logic                        pe_switch_out,
    output logic                        pe_drain_out,
    output logic [VW-1:0]               pe_weight_out,
    output logic [IW-1:0]               pe_index_out,
    output logic                        pe_accept_w_out,
    output logic [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
    output logic                        pe_psum_valid_out,
    output logic                        pe_overflow,
    output logic                        pe_collision
);
    localparam int WW = wide_w(DATA_WIDTH_ACCUM, LANES);

    pe_mode_e                      mode, prev_mode;
    logic [VW-1:0]                 w_active, w_inactive, a_vec;
    logic [DATA_WIDTH_ACCUM-1:0]   acc, res;
    logic signed [WW-1:0]          dot, psum_x, acc_x, sum;
    sat_t                          sr;
    logic                          mode_chg, eat, fwd, compute, ovf_evt, coll_evt;

    assign mode     = pe_mode_e'(pe_mode);
    assign mode_chg = mode != prev_mode;
    assign a_vec    = (mode == PE_MODE_OS) ? pe_weight_in : w_active;

    pe_dot_lanes #(.LANES(LANES), .DATA_WIDTH_IN(DATA_WIDTH_IN), .OUT_W(WW)) u_dot (
        .a  (a_vec),
        .b  (pe_input_in),
        .dot(dot)
    );

    assign psum_x = {{(WW-DATA_WIDTH_ACCUM){pe_psum_in[DATA_WIDTH_ACCUM-1]}}, pe_psum_in};
    assign acc_x  = {{(WW-DATA_WIDTH_ACCUM){acc[DATA_WIDTH_ACCUM-1]}}, acc};
    // A drain in OS restarts the tile, so the new beat is not added to the old accumulator.
    assign sum = (mode == PE_MODE_OS) ? (pe_drain_in ? dot : acc_x + dot) : psum_x + dot;
    assign sr  = sat_trunc({{(SAT_W-WW){sum[WW-1]}}, sum}, DATA_WIDTH_ACCUM, SATURATE != 0);
    assign res = sr.value[DATA_WIDTH_ACCUM-1:0];

    assign eat      = pe_accept_w_in && (pe_index_in == IW'(ROW_ID));
    assign fwd      = pe_enabled && ((mode == PE_MODE_OS) || (pe_accept_w_in && !eat));
    assign compute  = (mode == PE_MODE_OS) ? (pe_valid_in && pe_accept_w_in) : pe_valid_in;
    assign ovf_evt  = pe_enabled && !mode_chg && compute && sr.ovf;
    assign coll_evt = pe_enabled && !mode_chg && (mode == PE_MODE_OS) && pe_drain_in && pe_psum_valid_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_input_out      <= '0;
            pe_valid_out      <= 1'b0;
            pe_switch_out     <= 1'b0;
            pe_drain_out      <= 1'b0;
            pe_weight_out     <= '0;
            pe_index_out      <= '0;
            pe_accept_w_out   <= 1'b0;
            pe_psum_out       <= '0;
            pe_psum_valid_out <= 1'b0;
            pe_overflow       <= 1'b0;
            pe_collision      <= 1'b0;
            w_active          <= '0;
            w_inactive        <= '0;
            acc               <= '0;
            prev_mode         <= PE_MODE_WS;
        end else begin
            prev_mode       <= mode;
            pe_overflow     <= pe_overflow | ovf_evt;
            pe_collision    <= pe_collision | coll_evt;
            pe_input_out    <= pe_enabled ? pe_input_in : '0;
            pe_valid_out    <= pe_enabled & pe_valid_in;
            pe_switch_out   <= pe_enabled & pe_switch_in;
            pe_drain_out    <= pe_enabled & pe_drain_in;
            pe_weight_out   <= fwd ? pe_weight_in : '0;
            pe_index_out    <= fwd ? pe_index_in : '0;
            pe_accept_w_out <= fwd & pe_accept_w_in;
            if (!pe_enabled || mode_chg) begin
                w_active          <= '0;
                w_inactive        <= '0;
                acc               <= '0;
                pe_psum_out       <= pe_psum_in;
                pe_psum_valid_out <= pe_psum_valid_in;
            end else if (mode == PE_MODE_WS) begin
                if (eat) w_inactive <= pe_weight_in;
                if (pe_switch_in) w_active <= w_inactive;
                pe_psum_out       <= pe_valid_in ? res : pe_psum_in;
                pe_psum_valid_out <= pe_valid_in | pe_psum_valid_in;
            end else if (pe_drain_in) begin
                pe_psum_out       <= acc;
                pe_psum_valid_out <= 1'b1;
                acc               <= compute ? res : '0;
            end else begin
                pe_psum_out       <= pe_psum_in;
                pe_psum_valid_out <= pe_psum_valid_in;
                if (compute) acc <= res;
            end
        end
    end
endmodule

// File: tb/tb_pe_dual_mode.sv
// tb_pe_dual_mode: directed checks of WS load/eat/forward, OS accumulate/drain/collision,
// saturation vs wrap, column disable and asynchronous reset on three PE variants.
module tb_pe_dual_mode;
    logic        clk = 1'b0;
    logic        rst, en, mode, valid, sw, drain, acc_w, pv;
    logic [31:0] b, a, psum;
    logic [3:0]  idx;

    logic [31:0] b_o [3];
    logic [31:0] a_o [3];
    logic [3:0]  idx_o [3];
    logic        v_o [3];
    logic        sw_o [3];
    logic        dr_o [3];
    logic        aw_o [3];
    logic        pv_o [3];
    logic        ovf [3];
    logic        col [3];
    logic [31:0] ps0;
    logic [15:0] ps1, ps2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pe_dual_mode #(.ROW_ID(2), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(32),
                   .LANES(4), .SATURATE(1)) d0 (
        .clk(clk), .rst(rst), .pe_enabled(en), .pe_mode(mode), .pe_valid_in(valid),
        .pe_switch_in(sw), .pe_drain_in(drain), .pe_input_in(b), .pe_accept_w_in(acc_w),
        .pe_weight_in(a), .pe_index_in(idx), .pe_psum_in(psum), .pe_psum_valid_in(pv),
        .pe_input_out(b_o[0]), .pe_valid_out(v_o[0]), .pe_switch_out(sw_o[0]), .pe_drain_out(dr_o[0]),
        .pe_weight_out(a_o[0]), .pe_index_out(idx_o[0]), .pe_accept_w_out(aw_o[0]),
        .pe_psum_out(ps0), .pe_psum_valid_out(pv_o[0]), .pe_overflow(ovf[0]), .pe_collision(col[0]));

    pe_dual_mode #(.ROW_ID(2), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(16),
                   .LANES(4), .SATURATE(1)) d1 (
        .clk(clk), .rst(rst), .pe_enabled(en), .pe_mode(mode), .pe_valid_in(valid),
        .pe_switch_in(sw), .pe_drain_in(drain), .pe_input_in(b), .pe_accept_w_in(acc_w),
        .pe_weight_in(a), .pe_index_in(idx), .pe_psum_in(psum[15:0]), .pe_psum_valid_in(pv),
        .pe_input_out(b_o[1]), .pe_valid_out(v_o[1]), .pe_switch_out(sw_o[1]), .pe_drain_out(dr_o[1]),
        .pe_weight_out(a_o[1]), .pe_index_out(idx_o[1]), .pe_accept_w_out(aw_o[1]),
        .pe_psum_out(ps1), .pe_psum_valid_out(pv_o[1]), .pe_overflow(ovf[1]), .pe_collision(col[1]));

    pe_dual_mode #(.ROW_ID(2), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(16),
                   .LANES(4), .SATURATE(0)) d2 (
        .clk(clk), .rst(rst), .pe_enabled(en), .pe_mode(mode), .pe_valid_in(valid),
        .pe_switch_in(sw), .pe_drain_in(drain), .pe_input_in(b), .pe_accept_w_in(acc_w),
        .pe_weight_in(a), .pe_index_in(idx), .pe_psum_in(psum[15:0]), .pe_psum_valid_in(pv),
        .pe_input_out(b_o[2]), .pe_valid_out(v_o[2]), .pe_switch_out(sw_o[2]), .pe_drain_out(dr_o[2]),
        .pe_weight_out(a_o[2]), .pe_index_out(idx_o[2]), .pe_accept_w_out(aw_o[2]),
        .pe_psum_out(ps2), .pe_psum_valid_out(pv_o[2]), .pe_overflow(ovf[2]), .pe_collision(col[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; sw = 0; drain = 0; acc_w = 0; pv = 0;
        b = '0; a = '0; idx = '0; psum = '0;
    endtask

    task automatic os_beat();
        idle(); valid = 1; acc_w = 1; idx = 4'd2; a = 32'h0403_0201; b = 32'h0101_0101;
        step();
    endtask

    task automatic test_reset();
        rst = 0; en = 0; mode = 0; idle();
        #2 rst = 1;
        #2;
        n_chk++; if (ps0 !== 32'd0) begin n_fail++; $display("FAIL reset_psum: got %h want 0", ps0); end
        n_chk++; if (pv_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_psum_valid: got %b want 0", pv_o[0]); end
        n_chk++; if (aw_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_accept_w: got %b want 0", aw_o[0]); end
        n_chk++; if (ovf[1] !== 1'b0 || col[0] !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b col=%b want 0 0", ovf[1], col[0]); end
        step();
        rst = 0; en = 1;
    endtask

    task automatic test_ws_load();
        idle(); acc_w = 1; idx = 4'd2; a = 32'h0000_00FD;
        step();
        n_chk++; if (aw_o[0] !== 1'b0) begin n_fail++; $display("FAIL ws_eat_accept: got %b want 0", aw_o[0]); end
        n_chk++; if (a_o[0] !== 32'd0) begin n_fail++; $display("FAIL ws_eat_weight: got %h want 0", a_o[0]); end
        n_chk++; if (idx_o[0] !== 4'd0) begin n_fail++; $display("FAIL ws_eat_index: got %0d want 0", idx_o[0]); end
        idle(); sw = 1;
        step();
        n_chk++; if (sw_o[0] !== 1'b1) begin n_fail++; $display("FAIL ws_switch_fwd: got %b want 1", sw_o[0]); end
        idle(); valid = 1; b = 32'd5; psum = 32'd10;
        step();
        n_chk++; if (ps0 !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL ws_mac: got %0d want -5", $signed(ps0)); end
        n_chk++; if (pv_o[0] !== 1'b1) begin n_fail++; $display("FAIL ws_mac_valid: got %b want 1", pv_o[0]); end
        n_chk++; if (b_o[0] !== 32'd5 || v_o[0] !== 1'b1) begin n_fail++; $display("FAIL ws_east_fwd: got b=%h v=%b want 5 1", b_o[0], v_o[0]); end
        n_chk++; if (ps1 !== 16'hFFFB) begin n_fail++; $display("FAIL ws_mac16: got %h want fffb", ps1); end
    endtask

    task automatic test_ws_forward();
        idle(); acc_w = 1; idx = 4'd5; a = 32'd7;
        step();
        n_chk++; if (aw_o[0] !== 1'b1 || a_o[0] !== 32'd7 || idx_o[0] !== 4'd5) begin
            n_fail++; $display("FAIL ws_forward: got aw=%b w=%h idx=%0d want 1 7 5", aw_o[0], a_o[0], idx_o[0]); end
        idle(); sw = 1; step();
        idle(); valid = 1; b = 32'd5; psum = 32'd10;
        step();
        n_chk++; if (ps0 !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL ws_forward_keeps_inactive: got %0d want -5", $signed(ps0)); end
        idle(); acc_w = 1; idx = 4'd2; a = 32'd4; sw = 1; step();
        idle(); valid = 1; b = 32'd1; step();
        n_chk++; if (ps0 !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL ws_load_switch_old: got %0d want -3", $signed(ps0)); end
        idle(); sw = 1; step();
        idle(); valid = 1; b = 32'd1; step();
        n_chk++; if (ps0 !== 32'd4) begin n_fail++; $display("FAIL ws_load_switch_new: got %0d want 4", $signed(ps0)); end
        idle(); pv = 1; psum = 32'd123; step();
        n_chk++; if (ps0 !== 32'd123 || pv_o[0] !== 1'b1) begin n_fail++; $display("FAIL ws_psum_pass: got %0d v=%b want 123 1", ps0, pv_o[0]); end
        idle(); step();
        n_chk++; if (pv_o[0] !== 1'b0) begin n_fail++; $display("FAIL ws_psum_idle: got %b want 0", pv_o[0]); end
    endtask

    task automatic test_os();
        idle(); mode = 1; step();
        os_beat();
        n_chk++; if (a_o[0] !== 32'h0403_0201 || aw_o[0] !== 1'b1 || idx_o[0] !== 4'd2) begin
            n_fail++; $display("FAIL os_south_fwd: got w=%h aw=%b idx=%0d want 04030201 1 2", a_o[0], aw_o[0], idx_o[0]); end
        os_beat(); os_beat();
        idle(); drain = 1; step();
        n_chk++; if (ps0 !== 32'd30 || pv_o[0] !== 1'b1) begin n_fail++; $display("FAIL os_drain: got %0d v=%b want 30 1", ps0, pv_o[0]); end
        n_chk++; if (dr_o[0] !== 1'b1) begin n_fail++; $display("FAIL os_drain_fwd: got %b want 1", dr_o[0]); end
        idle(); drain = 1; step();
        n_chk++; if (ps0 !== 32'd0) begin n_fail++; $display("FAIL os_acc_cleared: got %0d want 0", ps0); end
        os_beat(); os_beat();
        idle(); valid = 1; acc_w = 1; a = 32'h0403_0201; b = 32'h0101_0101; drain = 1; step();
        n_chk++; if (ps0 !== 32'd20) begin n_fail++; $display("FAIL os_drain_with_beat: got %0d want 20", ps0); end
        idle(); drain = 1; step();
        n_chk++; if (ps0 !== 32'd10) begin n_fail++; $display("FAIL os_new_tile: got %0d want 10", ps0); end
        idle(); valid = 1; a = 32'h0403_0201; b = 32'h0101_0101; step();
        idle(); drain = 1; step();
        n_chk++; if (ps0 !== 32'd0) begin n_fail++; $display("FAIL os_no_accept_no_mac: got %0d want 0", ps0); end
        idle(); pv = 1; psum = 32'd77; step();
        n_chk++; if (ps0 !== 32'd77 || pv_o[0] !== 1'b1) begin n_fail++; $display("FAIL os_shift: got %0d v=%b want 77 1", ps0, pv_o[0]); end
    endtask

    task automatic test_collision();
        n_chk++; if (col[0] !== 1'b0) begin n_fail++; $display("FAIL coll_before: got %b want 0", col[0]); end
        os_beat();
        idle(); drain = 1; pv = 1; psum = 32'd99; step();
        n_chk++; if (ps0 !== 32'd10 || col[0] !== 1'b1) begin n_fail++; $display("FAIL coll_drain: got %0d col=%b want 10 1", ps0, col[0]); end
        idle(); step();
        n_chk++; if (ps0 === 32'd99 || pv_o[0] !== 1'b0) begin n_fail++; $display("FAIL coll_dropped: got %0d v=%b want 0 0", ps0, pv_o[0]); end
        n_chk++; if (col[0] !== 1'b1) begin n_fail++; $display("FAIL coll_sticky: got %b want 1", col[0]); end
    endtask

    task automatic test_sat();
        idle(); mode = 0; step();
        n_chk++; if (ovf[1] !== 1'b0) begin n_fail++; $display("FAIL sat_before: got %b want 0", ovf[1]); end
        idle(); acc_w = 1; idx = 4'd2; a = 32'd10; step();
        idle(); sw = 1; step();
        idle(); valid = 1; b = 32'd10; psum = 32'd32760; step();
        n_chk++; if (ps1 !== 16'h7FFF || ovf[1] !== 1'b1) begin n_fail++; $display("FAIL sat_pos: got %h ovf=%b want 7fff 1", ps1, ovf[1]); end
        n_chk++; if (ps2 !== 16'h805C || ovf[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_pos: got %h ovf=%b want 805c 1", ps2, ovf[2]); end
        n_chk++; if (ps0 !== 32'd32860 || ovf[0] !== 1'b0) begin n_fail++; $display("FAIL wide_no_ovf: got %0d ovf=%b want 32860 0", ps0, ovf[0]); end
        idle(); valid = 1; b = 32'h0000_00F6; psum = 32'hFFFF_8008; step();
        n_chk++; if (ps1 !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", ps1); end
        n_chk++; if (ps2 !== 16'h7FA4) begin n_fail++; $display("FAIL wrap_neg: got %h want 7fa4", ps2); end
        n_chk++; if (ps0 !== 32'hFFFF_7FA4) begin n_fail++; $display("FAIL wide_neg: got %h want ffff7fa4", ps0); end
        idle(); step();
        n_chk++; if (ovf[1] !== 1'b1 || ps1 !== 16'd0) begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b ps=%h want 1 0", ovf[1], ps1); end
    endtask

    task automatic test_disable();
        en = 0; idle(); pv = 1; psum = 32'd55; valid = 1; b = 32'd3; acc_w = 1; idx = 4'd5; a = 32'd9; step();
        n_chk++; if (ps0 !== 32'd55 || pv_o[0] !== 1'b1) begin n_fail++; $display("FAIL dis_psum_pass: got %0d v=%b want 55 1", ps0, pv_o[0]); end
        n_chk++; if (b_o[0] !== 32'd0 || v_o[0] !== 1'b0 || aw_o[0] !== 1'b0 || a_o[0] !== 32'd0) begin
            n_fail++; $display("FAIL dis_streams: got b=%h v=%b aw=%b w=%h want 0", b_o[0], v_o[0], aw_o[0], a_o[0]); end
        n_chk++; if (ovf[1] !== 1'b1) begin n_fail++; $display("FAIL dis_flag_hold: got %b want 1", ovf[1]); end
        en = 1; idle(); valid = 1; b = 32'd10; psum = 32'd1; step();
        n_chk++; if (ps0 !== 32'd1) begin n_fail++; $display("FAIL dis_weights_cleared: got %0d want 1", ps0); end
    endtask

    task automatic test_async_reset();
        idle(); mode = 1; step();
        os_beat(); os_beat();
        #3 rst = 1;
        #1;
        n_chk++; if (a_o[0] !== 32'd0 || aw_o[0] !== 1'b0) begin n_fail++; $display("FAIL areset_outputs: got w=%h aw=%b want 0 0", a_o[0], aw_o[0]); end
        n_chk++; if (ovf[1] !== 1'b0 || col[0] !== 1'b0) begin n_fail++; $display("FAIL areset_flags: got ovf=%b col=%b want 0 0", ovf[1], col[0]); end
        #2 rst = 0;
        idle(); step();
        idle(); drain = 1; step();
        n_chk++; if (ps0 !== 32'd0 || pv_o[0] !== 1'b1) begin n_fail++; $display("FAIL areset_drain: got %0d v=%b want 0 1", ps0, pv_o[0]); end
    endtask

    initial begin
        test_reset();
        test_ws_load();
        test_ws_forward();
        test_os();
        test_collision();
        test_sat();
        test_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_dual_mode.md
Name: pe_dual_mode

Overview:
- Next-generation systolic processing element. Adds LANES-wide dot-product MAC, runtime-selectable weight-stationary (WS) or output-stationary (OS) dataflow, optional saturating accumulation and sticky error flags.
- WS mode: double-buffered weights loaded by index match with signal-eating; psum flows north-to-south.
- OS mode: A streams south, B streams east, the result accumulates locally and drains down the psum chain on command.
- Instantiated per grid cell by the systolic array top.

Parameters:
- ROW_ID, 0: static row index of this PE; matched against pe_index_in in WS mode.
- SYSTOLIC_ARRAY_WIDTH, 16: array dimension; index width IW = $clog2(SYSTOLIC_ARRAY_WIDTH).
- DATA_WIDTH_IN, 8: signed element width of A and B.
- DATA_WIDTH_ACCUM, 32: signed accumulator/psum width.
- LANES, 1: elements per beat; MAC computes a LANES-term dot product.
- SATURATE, 1: 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pe_enabled  in  1  column enable
- pe_mode  in  1  0 = WS, 1 = OS (quasi-static)
- pe_valid_in  in  1  B beat valid (west)
- pe_switch_in  in  1  WS: inactive-to-active weight swap (west)
- pe_drain_in  in  1  OS: load accumulator onto psum chain (west)
- pe_input_in  in  LANES*DATA_WIDTH_IN  B vector (west), lane 0 in LSBs
- pe_accept_w_in  in  1  A beat valid (north)
- pe_weight_in  in  LANES*DATA_WIDTH_IN  A vector (north)
- pe_index_in  in  IW  target row of A (north, WS only)
- pe_psum_in  in  DATA_WIDTH_ACCUM  psum (north)
- pe_psum_valid_in  in  1  psum valid (north)
- pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out  out  as inputs  east, 1-cycle delayed
- pe_weight_out, pe_index_out, pe_accept_w_out  out  as inputs  south
- pe_psum_out  out  DATA_WIDTH_ACCUM  psum (south)
- pe_psum_valid_out  out  1  psum valid (south)
- pe_overflow  out  1  sticky: an accumulation exceeded range
- pe_collision  out  1  sticky: OS drain coincided with pe_psum_valid_in

Behaviour:
- Reset (async): every output and all internal registers (w_active, w_inactive, acc, prev_mode) go to 0. Deassertion is synchronous to clk at the top level.
- All outputs are registered; every path has 1-cycle latency.
- Dot product: dot = sum over lanes of signed(B[i]) * signed(A_or_Wactive[i]). Intermediate products are full width; accumulate at DATA_WIDTH_ACCUM+$clog2(LANES)+1 bits, then range-check.
- Range check: if the result is out of signed DATA_WIDTH_ACCUM range, set pe_overflow. With SATURATE=1, clamp to max/min; with SATURATE=0, truncate.
- pe_enabled=0:
  - East and south streams forced to 0: inputs, valids, switch, drain, weight, index, accept_w.
  - psum and psum_valid pass through from north.
  - w_active, w_inactive and acc cleared. Sticky flags hold.
- WS mode (pe_mode=0):
  - psum_out = valid_in ? sat(dot(B, w_active) + psum_in) : psum_in.
  - psum_valid_out = pe_valid_in | pe_psum_valid_in.
  - Weight load with accept_w_in=1 and index == ROW_ID: w_inactive <= weight_in; accept_w_out=0; weight_out=0; index_out=0 (signal eaten).
  - Weight load with accept_w_in=1 and no match: forward weight, index and accept_w.
  - accept_w_in=0: south weight, index and accept_w outputs are 0.
  - switch_in: w_active <= w_inactive. If a matching load and a switch land in the same cycle, w_active takes the OLD w_inactive; the new weight lands in w_inactive.
  - drain_in is forwarded east and otherwise ignored.
- OS mode (pe_mode=1):
  - A forwards south unconditionally, with accept_w as its valid; no index match and no eating. index_out = index_in.
  - When valid_in & accept_w_in: acc <= sat(acc + dot(B, A)).
  - drain_in=1: psum_out <= acc; psum_valid_out <= 1; acc <= (valid_in & accept_w_in) ? sat(dot(B, A)) : 0, i.e. a new tile may start the same cycle.
  - drain_in=1 with psum_valid_in=1: the upstream item is dropped and pe_collision is set.
  - drain_in=0: psum_out <= psum_in; psum_valid_out <= psum_valid_in (shift chain).
  - switch_in is forwarded east; weights are untouched.
- Mode change: when pe_mode differs from prev_mode, clear acc, w_active and w_inactive that cycle and ignore compute. prev_mode registers pe_mode.

Decomposition:
- Package pe_pkg holds:
  - mode enum pe_mode_e {PE_MODE_WS, PE_MODE_OS};
  - function sat_trunc(wide value, width) returning the clamped value and an overflow bit;
  - localparams for the widened accumulator width.
- Sub-module pe_dot_lanes (parametrised LANES, DATA_WIDTH_IN): combinational signed dot product returning the wide sum. Shared by both modes.

Test Plan:
- WS load/eat, ROW_ID=2, LANES=1: accept_w=1, index=2, weight=-3, then switch, then B=5 with psum_in=10 → next cycle psum_out=-5, psum_valid_out=1. During the load cycle accept_w_out=0 and weight_out=0.
- WS forward, ROW_ID=2: index=5, weight=7 → accept_w_out=1, weight_out=7, index_out=5 one cycle later; w_inactive unchanged.
- OS accumulate/drain, LANES=4: A={1,2,3,4}, B={1,1,1,1} for 3 beats → drain gives psum_out=30, valid=1; acc=0 after.
- Saturation, SATURATE=1, ACCUM=16: psum_in=32760, B=10, A=10 (WS) → psum_out=32767, pe_overflow=1 and stays 1. With SATURATE=0 → -32676.
- Collision: in OS mode, drain_in=1 with psum_valid_in=1, psum_in=99 → psum_out=acc, pe_collision=1, 99 never appears.
- Async reset mid-OS-accumulation, rst asserted between clock edges → all outputs 0 immediately. After release, first drain yields 0.
